xor_descrambler_n: RTL and testbench
====================================

# xor_descrambler_n

Sequential N-bit additive descrambler, the receive-side counterpart of the ALU's bitwise XOR stage. It recovers plain words from a stream that was XOR-masked with a 7-bit LFSR keystream by XORing each accepted word with the same keystream. It sits between an operand source and the ALU operand inputs, with a valid/ready handshake on both sides and a single registered output stage.

## Interface
- N, 6, data word width; legal range 1..7.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- seed_load  input  1  load `seed` into the LFSR this cycle.
- seed  input  7  LFSR seed value.
- in_valid  input  1  `in_data` is valid.
- in_ready  output  1  block accepts `in_data` this cycle.
- in_data  input  N  masked word.
- out_valid  output  1  `out_data` holds a descrambled word.
- out_ready  input  1  downstream accepts `out_data`.
- out_data  output  N  descrambled word.
- word_count  output  8  number of words accepted since reset or the last seed load; wraps.

## Operation
- Reset values: LFSR = 7'h7F, out_valid = 0, out_data = 0, word_count = 0.
- LFSR is Fibonacci type with polynomial x^7+x^6+1.
  - fb = s[6] ^ s[5].
  - next = {s[5:0], fb}.
- Keystream word is key = s[N-1:0] for the current state s.
- in_ready = !seed_load && (!out_valid || out_ready).
- Accept occurs when in_valid && in_ready. On accept:
  - out_data <= in_data ^ key.
  - out_valid <= 1.
  - LFSR advances exactly one step.
  - word_count increments by 1, mod 256.
- Output retire occurs when out_valid && out_ready and there is no accept in the same cycle. On retire, out_valid <= 0. out_data holds its last value.
- Output state machine:
  - EMPTY (out_valid = 0) goes to FULL on accept.
  - FULL goes to FULL on accept together with out_ready (pass-through).
  - FULL goes to EMPTY on retire.
  - FULL stays FULL with data held stable while out_ready = 0.
- Seed load has priority over everything else:
  - LFSR <= seed, or 7'h7F if seed == 0 (prevents lock-up).
  - word_count <= 0.
  - No accept occurs that cycle, because in_ready is forced low.
  - A pending output word is unaffected and may still retire that cycle.
- The LFSR never advances without an accept. Stalls do not consume keystream.
- Self-inverse property: feeding this block's output into a copy seeded identically reproduces the original masked stream.

## Timing
- Latency is 1 cycle: a word accepted at edge t is visible on out_data with out_valid = 1 after edge t.
- Throughput is 1 word/cycle while out_ready = 1 and seed_load = 0.
- in_ready is combinational from out_valid, out_ready and seed_load. There is no combinational path from in_valid to in_ready.
- Under backpressure, out_data and out_valid are stable until retire.
- Asynchronous reset mid-stream:
  - Outputs clear immediately.
  - The in-flight word is discarded.
  - LFSR returns to 7'h7F.
  - Accept is possible on the first clock edge after rst_n rises.
- word_count wraps from 255 to 0 on the 256th accept.

## Test plan
- Reset, then send in_data 6'h00 three times with out_ready = 1 → out_data is 6'h3F, 6'h3E, 6'h3C on consecutive cycles; word_count = 3.
- seed_load with seed = 7'h01, then send 6'h00 three times → outputs 6'h01, 6'h02, 6'h04. During the seed_load cycle in_ready = 0 and word_count resets to 0.
- seed_load with seed = 7'h00 → behaves exactly as seed 7'h7F; first output for in_data 6'h00 is 6'h3F.
- Backpressure: accept 6'h15 with out_ready = 0 → out_data = 6'h2A with out_valid held, in_ready = 0, LFSR frozen for 5 cycles. Raising out_ready with in_valid = 1 and in_data 6'h00 → out_data becomes 6'h3E the next cycle.
- Round-trip: chain two instances with seed 7'h5A and drive 300 random words → second instance's output equals the original input, and word_count reads 300 mod 256 = 44.
- Assert rst_n low while out_valid = 1 → out_valid, out_data and word_count are 0 immediately; next accept of 6'h00 yields 6'h3F.

Source files
------------

// File: rtl/xor_descrambler_n.sv
// xor_descrambler_n: N-bit additive descrambler. Each accepted word is XORed
// with the low N bits of a 7-bit Fibonacci LFSR (x^7 + x^6 + 1). The LFSR
// advances only when a word is accepted. The result goes to a single
// registered output stage that has a valid/ready handshake.
module xor_descrambler_n #(
    parameter int N = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         seed_load,
    input  logic [6:0]   seed,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic [7:0]   word_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [6:0]   lfsr;
    logic [N-1:0] key;
    logic         accept;
    logic         retire;

    assign key       = lfsr[N-1:0];
    assign out_valid = (state == FULL);

    // in_ready depends only on registered state, out_ready and seed_load.
    // in_valid never reaches it, so there is no combinational loop through upstream.
    assign in_ready = !seed_load && ((state == EMPTY) || out_ready);
    assign accept   = in_valid && in_ready;
    assign retire   = (state == FULL) && out_ready && !accept;

    // Output stage next-state logic: an accept always fills the stage, and a lone retire empties it.
    always_comb begin
        // NOTE: assigning the default first means that every path drives
        // state_next, so no latch is inferred.
        state_next = state;
        case (state)
            EMPTY: if (accept) state_next = FULL;
            FULL:  if (retire) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    // Output stage state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: use non-blocking assignments for all sequential state, so that every
        // register samples values from before the edge.
        if (!rst_n) state <= EMPTY;
        else        state <= state_next;
    end

    // Keystream generator. A seed load takes priority, and an all-zero seed
    // maps to 7'h7F so that the LFSR cannot lock up. Stalls do not consume keystream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= 7'h7F;
        end else if (seed_load) begin
            lfsr <= (seed == 7'd0) ? 7'h7F : seed;
        end else if (accept) begin
            lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
        end
    end

    // Accepted-word counter. It clears on seed load and wraps modulo 256.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_count <= 8'd0;
        end else if (seed_load) begin
            word_count <= 8'd0;
        end else if (accept) begin
            word_count <= word_count + 8'd1;
        end
    end

    // Output data register. It loads the descrambled word on accept and holds it otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: this datapath register has a reset because out_data must read
        // zero straight after reset. It is not left uninitialised like plain storage.
        if (!rst_n) begin
            out_data <= '0;
        end else if (accept) begin
            out_data <= in_data ^ key;
        end
    end

endmodule

// File: tb/tb_xor_descrambler_n.sv
// Testbench for xor_descrambler_n. A behavioural model is checked against the DUT
// on every cycle. Directed scenarios carry hand-computed literal values, and a
// chain of two instances covers the self-inverse round trip.
module tb_xor_descrambler_n;

    localparam int N = 6;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         seed_load;
    logic [6:0]   seed;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic [7:0]   word_count;

    // Signals for the round-trip chain: ra scrambles raw words, rb recovers them.
    logic         rt_seed_load;
    logic         rt_valid;
    logic [N-1:0] rt_data;
    logic         rt_out_ready;
    logic         a_in_ready, a_out_valid, b_in_ready, b_out_valid;
    logic [N-1:0] a_out_data, b_out_data;
    logic [7:0]   a_wc, b_wc;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    xor_descrambler_n #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .word_count(word_count)
    );

    xor_descrambler_n #(.N(N)) ra (
        .clk(clk), .rst_n(rst_n), .seed_load(rt_seed_load), .seed(7'h5A),
        .in_valid(rt_valid), .in_ready(a_in_ready), .in_data(rt_data),
        .out_valid(a_out_valid), .out_ready(b_in_ready), .out_data(a_out_data),
        .word_count(a_wc)
    );

    xor_descrambler_n #(.N(N)) rb (
        .clk(clk), .rst_n(rst_n), .seed_load(rt_seed_load), .seed(7'h5A),
        .in_valid(a_out_valid), .in_ready(b_in_ready), .in_data(a_out_data),
        .out_valid(b_out_valid), .out_ready(rt_out_ready), .out_data(b_out_data),
        .word_count(b_wc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [6:0] lfsr_step(input logic [6:0] s);
        return {s[5:0], s[6] ^ s[5]};
    endfunction

    logic [6:0]   m_lfsr;
    logic         m_valid;
    logic [N-1:0] m_data;
    logic [7:0]   m_count;
    logic         m_in_ready;

    assign m_in_ready = !seed_load && (!m_valid || out_ready);

    // The model applies the transfer rules: seed load first, then accept, then retire.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr  <= 7'h7F;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_count <= 8'd0;
        end else if (seed_load) begin
            m_lfsr  <= (seed == 7'd0) ? 7'h7F : seed;
            m_count <= 8'd0;
            if (m_valid && out_ready) m_valid <= 1'b0;
        end else if (in_valid && m_in_ready) begin
            m_data  <= in_data ^ m_lfsr[N-1:0];
            m_valid <= 1'b1;
            m_lfsr  <= lfsr_step(m_lfsr);
            m_count <= m_count + 8'd1;
        end else if (m_valid && out_ready) begin
            m_valid <= 1'b0;
        end
    end

    // Compare the DUT with the model on every falling edge while out of reset.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("cmp_in_ready",   in_ready,   m_in_ready);
            check("cmp_out_valid",  out_valid,  m_valid);
            check("cmp_out_data",   out_data,   m_data);
            check("cmp_word_count", word_count, m_count);
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [N-1:0] q[$];
        int sent, got;
        logic acc_a, ret_b;

        rst_n = 1'b0;
        seed_load = 1'b0; seed = 7'd0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        rt_seed_load = 1'b0; rt_valid = 1'b0; rt_data = '0; rt_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid",  out_valid,  1'b0);
        check("rst_out_data",   out_data,   6'h00);
        check("rst_word_count", word_count, 8'd0);

        // Release reset with a word already offered. It is accepted on the first edge.
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b1; in_data = 6'h00; out_ready = 1'b1;
        tick(); check("t1_w0", out_data, 6'h3F);
        tick(); check("t1_w1", out_data, 6'h3E);
        tick(); check("t1_w2", out_data, 6'h3C);
        in_valid = 1'b0;
        check("t1_count", word_count, 8'd3);

        // Seed 7'h01. in_ready is forced low and the counter clears.
        seed_load = 1'b1; seed = 7'h01; in_valid = 1'b1; in_data = 6'h00;
        #1 check("t2_seed_in_ready", in_ready, 1'b0);
        tick(); seed_load = 1'b0;
        check("t2_count_clr", word_count, 8'd0);
        tick(); check("t2_w0", out_data, 6'h01);
        tick(); check("t2_w1", out_data, 6'h02);
        tick(); check("t2_w2", out_data, 6'h04);
        in_valid = 1'b0;
        check("t2_count", word_count, 8'd3);

        // A zero seed behaves like seed 7'h7F.
        seed_load = 1'b1; seed = 7'h00;
        tick(); seed_load = 1'b0; in_valid = 1'b1; in_data = 6'h00;
        tick(); check("t3_w0", out_data, 6'h3F);
        in_valid = 1'b0;

        // Backpressure holds the word, and the LFSR stays frozen.
        seed_load = 1'b1; seed = 7'h00;
        tick(); seed_load = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_data = 6'h15;
        tick();
        check("t4_data", out_data, 6'h2A);
        check("t4_valid", out_valid, 1'b1);
        in_data = 6'h00;
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_ready", in_ready, 1'b0);
            check("t4_hold_data", out_data, 6'h2A);
            check("t4_hold_valid", out_valid, 1'b1);
            tick();
        end
        out_ready = 1'b1;
        #1 check("t4_release_ready", in_ready, 1'b1);
        tick(); check("t4_pass", out_data, 6'h3E);
        check("t4_count", word_count, 8'd2);
        in_valid = 1'b0;

        // word_count wraps on the 256th accept.
        seed_load = 1'b1; seed = 7'h03;
        tick(); seed_load = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 255; i++) begin
            in_data = 6'($urandom);
            tick();
        end
        check("t5_count_255", word_count, 8'd255);
        tick();
        check("t5_count_wrap", word_count, 8'd0);
        in_valid = 1'b0;

        // Random traffic. The compare process checks every cycle.
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 6'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            seed_load = ($urandom_range(0, 15) == 0);
            seed      = ($urandom_range(0, 3) == 0) ? 7'h00 : 7'($urandom);
            tick();
        end
        seed_load = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();

        // Asynchronous reset while a word is pending.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 6'h2B;
        tick();
        check("t7_pending", out_valid, 1'b1);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("t7_rst_valid", out_valid, 1'b0);
        check("t7_rst_data",  out_data,  6'h00);
        check("t7_rst_count", word_count, 8'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b1; in_data = 6'h00; out_ready = 1'b1;
        tick(); check("t7_after_rst", out_data, 6'h3F);
        in_valid = 1'b0;

        // Round trip through two identically seeded instances.
        rt_seed_load = 1'b1; rt_out_ready = 1'b1;
        tick(); rt_seed_load = 1'b0;
        rt_valid = 1'b1; rt_data = 6'($urandom);
        sent = 0; got = 0;
        for (int cyc = 0; cyc < 5000 && got < 300; cyc++) begin
            @(negedge clk);
            acc_a = rt_valid && a_in_ready;
            ret_b = b_out_valid && rt_out_ready;
            if (ret_b) begin
                if (q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL rt_underflow: got output with no word in flight");
                end else begin
                    check("rt_data", b_out_data, q.pop_front());
                end
                got++;
            end
            if (acc_a) begin
                q.push_back(rt_data);
                sent++;
            end
            @(posedge clk);
            #1;
            if (acc_a || !rt_valid) begin
                if (sent < 300) begin
                    rt_valid = ($urandom_range(0, 3) != 0);
                    rt_data  = 6'($urandom);
                end else begin
                    rt_valid = 1'b0;
                end
            end
            rt_out_ready = ($urandom_range(0, 3) != 0);
        end
        check("rt_received", got, 300);
        check("rt_a_count", a_wc, 8'd44);
        check("rt_b_count", b_wc, 8'd44);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
